// File: rtl/banco_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : banco_reg_pkg
//  Purpose  : Shared defaults, zero-register constant and port packing helper
//             for the scoreboarded register bank.
//  Revision : 1.0  initial release
// ============================================================================
package banco_reg_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NREAD  = 2;

   localparam logic [DEF_ADDR_W-1:0] ZERO_ADDR = '0;

   // Base bit offset of port i inside a flat bus of w-bit fields.
   function automatic int pack_idx(input int i, input int w);
      return i * w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/banco_reg_rport.sv
`default_nettype none
// ============================================================================
//  Module   : banco_reg_rport
//  Purpose  : One combinational read port: zero register, write bypass,
//             read mux and pending-bit masking.
//  Revision : 1.0  initial release
// ============================================================================
module banco_reg_rport
   import banco_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic [ADDR_W-1:0] ra,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_pend,
   output logic [DATA_W-1:0] rd,
   output logic              rd_pend
);

   logic w_is_zero;
   logic w_hit;

   assign w_is_zero = (ra == ADDR_W'(ZERO_ADDR));
   assign w_hit     = (BYPASS != 0) && we && (wa == ra);

   // A bypassed value is being delivered now, so it no longer counts as pending.
   always_comb begin
      rd      = mem_data;
      rd_pend = mem_pend;
      if (w_is_zero) begin
         rd      = '0;
         rd_pend = 1'b0;
      end else if (w_hit) begin
         rd      = wd;
         rd_pend = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/banco_reg_sb.sv
`default_nettype none
// ============================================================================
//  Module   : banco_reg_sb
//  Purpose  : Multi-read-port register bank with a per-register pending-write
//             scoreboard for RAW/WAW hazard detection.
//  Revision : 1.0  initial release
// ============================================================================
module banco_reg_sb
   import banco_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREAD  = DEF_NREAD,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREAD*ADDR_W-1:0] ra,
   output logic [NREAD*DATA_W-1:0] rd,
   output logic [NREAD-1:0]        rd_pend,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       wa,
   input  logic [DATA_W-1:0]       wd,
   input  logic                    alloc_en,
   input  logic [ADDR_W-1:0]       alloc_addr,
   output logic                    alloc_busy,
   output logic [ADDR_W:0]         pend_cnt
);

   localparam int c_depth = 2 ** ADDR_W;

   logic [DATA_W-1:0]  r_mem [c_depth];
   logic [c_depth-1:0] r_pend;
   logic [ADDR_W:0]    r_pend_cnt;

   logic               w_wr_ok;
   logic               w_alloc_ok;
   logic               w_set;
   logic               w_clr;
   logic [c_depth-1:0] w_pend_nxt;
   logic [ADDR_W:0]    w_cnt_nxt;

   assign w_wr_ok    = we && (wa != ADDR_W'(ZERO_ADDR));
   assign w_alloc_ok = alloc_en && (alloc_addr != ADDR_W'(ZERO_ADDR));

   // Alloc is applied last so a new producer overrides a same-cycle clear.
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_wr_ok)
         w_pend_nxt[wa] = 1'b0;
      if (w_alloc_ok)
         w_pend_nxt[alloc_addr] = 1'b1;
   end

   // Counter tracks only real transitions, so it stays equal to the popcount.
   assign w_set     = w_alloc_ok && !r_pend[alloc_addr];
   assign w_clr     = w_wr_ok && r_pend[wa] && !(w_alloc_ok && (alloc_addr == wa));
   assign w_cnt_nxt = r_pend_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < c_depth; k++)
            r_mem[k] <= '0;
         r_pend     <= '0;
         r_pend_cnt <= '0;
      end else begin
         if (w_wr_ok)
            r_mem[wa] <= wd;
         r_pend     <= w_pend_nxt;
         r_pend_cnt <= w_cnt_nxt;
      end
   end

   assign alloc_busy = r_pend[alloc_addr];
   assign pend_cnt   = r_pend_cnt;

   for (genvar i = 0; i < NREAD; i++) begin : g_rport
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = ra[pack_idx(i, ADDR_W) +: ADDR_W];

      banco_reg_rport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_rport (
         .ra       (w_ra),
         .we       (we),
         .wa       (wa),
         .wd       (wd),
         .mem_data (r_mem[w_ra]),
         .mem_pend (r_pend[w_ra]),
         .rd       (rd[pack_idx(i, DATA_W) +: DATA_W]),
         .rd_pend  (rd_pend[i])
      );
   end

endmodule
`default_nettype wire
